// File: rtl/qdiv_pkg.sv
// Shared definitions for the divider scheduler: FSM encoding, default
// word format and the divide-by-zero saturation value.
package qdiv_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_Q = 15;
  localparam int MAX_N = 64;

  // Scheduler FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Saturated sign-magnitude value for an n-bit word: {sign, all-ones magnitude}.
  // Returned MAX_N wide; callers size-cast to their own word width.
  function automatic logic [MAX_N-1:0] sat_q(input logic sign, input int n);
    logic [MAX_N-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n - 1) v[i] = 1'b1;
      else if (i == n - 1) v[i] = sign;
    end
    return v;
  endfunction

endpackage

// File: rtl/qdiv_sched_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward (wrapping) for the
// first active request. The pointer moves to winner+1 whenever a grant is
// issued, so a continuously requesting input waits at most NUM_REQ grants.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_cand;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;
  int                 w_pos;

  // Priority scan starting at the pointer, wrapping at NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(r_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_cand = ID_W'(w_pos);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // One-hot grant, only while the scheduler is able to accept
  always_comb begin
    w_grant = '0;
    if (i_en && w_found) w_grant[w_idx] = 1'b1;
  end

  // Pointer advances past the winner on every issued grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;

endmodule

// File: rtl/qdiv_sched.sv
// Shares one serial sign-magnitude divider between NUM_REQ requesters.
// Round-robin grant, start/complete sequencing with the divider, local
// divide-by-zero trap, and a single tagged valid/ready response channel.
//
// Handshakes: a request transfers on the cycle req_valid[i] & req_ready[i]
// are both high; a response transfers on the cycle rsp_valid & rsp_ready are
// both high. rsp_valid, once raised, stays high with rsp_quotient, rsp_id and
// rsp_div0 unchanged until that transfer happens.
module qdiv_sched
  import qdiv_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int Q       = DEF_Q,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_dividend,
  input  logic [NUM_REQ*N-1:0] req_divisor,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_quotient,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_div0,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  output logic                 div_start,
  input  logic [N-1:0]         div_quotient,
  input  logic                 div_complete,
  output logic                 busy
);

  // Reject parameter sets the datapath cannot represent
  if (NUM_REQ < 2 || ID_W != $clog2(NUM_REQ) || Q >= N - 1 || N > MAX_N) begin : g_param_check
    $error("qdiv_sched: inconsistent parameters");
  end

  state_t              r_state;
  logic                r_div_start;
  logic [N-1:0]        r_div_dividend;
  logic [N-1:0]        r_div_divisor;
  logic                r_rsp_valid;
  logic [N-1:0]        r_rsp_quotient;
  logic [ID_W-1:0]     r_rsp_id;
  logic                r_rsp_div0;

  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_accept;
  logic [N-1:0]        w_sel_dividend;
  logic [N-1:0]        w_sel_divisor;
  logic                w_div0;
  logic [N-1:0]        w_sat;

  // Grants only in IDLE and only when the divider reports idle; this also
  // covers a division still running from before a reset.
  assign w_arb_en = (r_state == ST_IDLE) && div_complete;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_valid),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_accept       = |w_grant;
  assign w_sel_dividend = req_dividend[int'(w_idx) * N +: N];
  assign w_sel_divisor  = req_divisor[int'(w_idx) * N +: N];
  // Negative zero counts as zero: only the magnitude is inspected
  assign w_div0         = (w_sel_divisor[N-2:0] == '0);
  assign w_sat          = N'(sat_q(w_sel_dividend[N-1] ^ w_sel_divisor[N-1], N));

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_div_start    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_quotient <= '0;
      r_rsp_id       <= '0;
      r_rsp_div0     <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rsp_id <= w_idx;
            if (w_div0) begin
              // Trap locally; the divider is never started
              r_rsp_quotient <= w_sat;
              r_rsp_div0     <= 1'b1;
              r_rsp_valid    <= 1'b1;
              r_state        <= ST_RESP;
            end else begin
              r_div_dividend <= w_sel_dividend;
              r_div_divisor  <= w_sel_divisor;
              r_div_start    <= 1'b1;
              r_state        <= ST_START;
            end
          end
        end
        ST_START: begin
          r_state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!div_complete) r_state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          if (div_complete) begin
            r_rsp_quotient <= div_quotient;
            r_rsp_div0     <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = w_grant;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_quotient = r_rsp_quotient;
  assign rsp_id       = r_rsp_id;
  assign rsp_div0     = r_rsp_div0;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign div_start    = r_div_start;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qdiv_sched.sv
// Bench for qdiv_sched with a serial N=32, Q=15 divider model
// (complete low for 46 cycles after each start pulse).
module tb_qdiv_sched;

  localparam int N       = 32;
  localparam int Q       = 15;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int L       = 46;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_dividend = '0;
  logic [NUM_REQ*N-1:0] req_divisor = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [N-1:0]         rsp_quotient;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_div0;
  logic [N-1:0]         div_dividend;
  logic [N-1:0]         div_divisor;
  logic                 div_start;
  logic [N-1:0]         div_quotient;
  logic                 div_complete;
  logic                 busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;

  qdiv_sched #(.N(N), .Q(Q), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_id       (rsp_id),
    .rsp_div0     (rsp_div0),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_start    (div_start),
    .div_quotient (div_quotient),
    .div_complete (div_complete),
    .busy         (busy)
  );

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (div_start) start_cnt = start_cnt + 1;
  end

  // ---------------- divider model (no reset, like the real one) ----------------
  int           m_cnt = 0;
  logic [N-1:0] m_q = '0;

  function automatic logic [N-1:0] model_div(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [63:0] num;
    logic [63:0] den;
    logic [63:0] quo;
    num = {33'd0, a[N-2:0]} << Q;
    den = {33'd0, b[N-2:0]};
    quo = (den == 64'd0) ? '1 : num / den;
    return {a[N-1] ^ b[N-1], quo[N-2:0]};
  endfunction

  always @(posedge clk) begin
    if (div_start) begin
      m_cnt <= L;
      m_q   <= model_div(div_dividend, div_divisor);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign div_complete = (m_cnt == 0);
  assign div_quotient = m_q;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // ---------------- driver tasks ----------------
  // Raise a request and wait for its grant; acc = cycle number of the accept cycle.
  task automatic issue(input int id, input logic [N-1:0] a, input logic [N-1:0] b, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_dividend[id*N +: N] = a;
    req_divisor[id*N +: N] = b;
    while (acc < 0 && n < 400) begin
      @(negedge clk);
      if (req_ready[id]) acc = cyc;
      n++;
    end
    if (acc < 0) note_timeout($sformatf("accept_req%0d", id));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // Wait for rsp_valid; lat = cycles from accept cycle to first rsp_valid cycle.
  task automatic wait_rsp(input int acc, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (lat < 0 && n < 400) begin
      @(negedge clk);
      if (rsp_valid) lat = cyc - acc;
      n++;
    end
    if (lat < 0) note_timeout("rsp_valid");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic         div0;
    int           lat;
  } vec_t;

  vec_t vecs[7];
  int   fair_exp[8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    int lat;
    int s0;
    int n;
    int ok;
    int viol;
    int gcyc;
    int hs;
    logic got;

    vecs[0] = '{0, 32'h00018000, 32'h00010000, 32'h0000C000, 1'b0, 49}; //  3.0 /  2.0
    vecs[1] = '{2, 32'h80008000, 32'h00020000, 32'h80002000, 1'b0, 49}; // -1.0 /  4.0
    vecs[2] = '{1, 32'h80028000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1};  // -5.0 / -0
    vecs[3] = '{1, 32'h80028000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1};  // -5.0 / +0
    vecs[4] = '{3, 32'h00030000, 32'h80018000, 32'h80010000, 1'b0, 49}; //  6.0 / -3.0
    vecs[5] = '{0, 32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, 49}; //  1.0 /  3.0
    vecs[6] = '{3, 32'h00000000, 32'h00010000, 32'h00000000, 1'b0, 49}; //  0.0 /  2.0
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_quotient", rsp_quotient, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_div0", rsp_div0, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_operands", {div_dividend, div_divisor}, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single operations
    for (int v = 0; v < 7; v++) begin
      s0 = start_cnt;
      issue(vecs[v].id, vecs[v].a, vecs[v].b, acc);
      wait_rsp(acc, lat);
      check($sformatf("vec%0d_quotient", v), rsp_quotient, vecs[v].q);
      check($sformatf("vec%0d_id", v), rsp_id, vecs[v].id);
      check($sformatf("vec%0d_div0", v), rsp_div0, vecs[v].div0);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("vec%0d_start_pulses", v), start_cnt - s0, vecs[v].div0 ? 0 : 1);
      if (!vecs[v].div0) begin
        check($sformatf("vec%0d_div_operands", v), {div_dividend, div_divisor}, {vecs[v].a, vecs[v].b});
      end
      @(posedge clk); #1;
    end

    // Backpressure: response held, another requester waiting
    rsp_ready = 1'b0;
    issue(3, 32'h00048000, 32'h00018000, acc); // 9.0 / 3.0
    req_valid[0] = 1'b1;
    req_dividend[0 +: N] = 32'h00008000;
    req_divisor[0 +: N] = 32'h00008000;
    wait_rsp(acc, lat);
    check("bp_latency", lat, 49);
    check("bp_quotient", rsp_quotient, 32'h00018000);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_quotient == 32'h00018000 && rsp_id == 2'd3 && !rsp_div0 &&
          req_ready == '0 && !div_start && busy) ok++;
    end
    check("bp_hold_cycles", ok, 20);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_rsp_valid", rsp_valid, 0);
    check("bp_release_grant", req_ready, 4'b0001);
    acc = cyc;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(acc, lat);
    check("bp_next_quotient", rsp_quotient, 32'h00008000);
    check("bp_next_id", rsp_id, 0);
    @(posedge clk); #1;

    // Fairness: all requesters valid, pointer reset to 0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dividend[i*N +: N] = 32'h00008000;
      req_divisor[i*N +: N] = 32'h00008000;
    end
    req_valid = '1;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      gcyc = 0;
      n = 0;
      while (!got && n < 100) begin
        @(negedge clk);
        if (req_ready != '0) begin
          got = 1'b1;
          gcyc = cyc;
        end
        n++;
      end
      if (!got) note_timeout($sformatf("fair_grant%0d", k));
      check($sformatf("fair_grant%0d", k), req_ready, 64'd1 << fair_exp[k]);
      if (k > 0) check($sformatf("fair_gap%0d", k), gcyc - hs, 1);
      wait_rsp(gcyc, lat);
      hs = cyc;
      check($sformatf("fair_id%0d", k), rsp_id, fair_exp[k]);
      check($sformatf("fair_quotient%0d", k), rsp_quotient, 32'h00008000);
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Reset while the divider is busy
    issue(1, 32'h00018000, 32'h00010000, acc);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (div_start) got = 1'b1;
      n++;
    end
    if (!got) note_timeout("rst_mid_start");
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_div_start", div_start, 0);
    check("mid_rst_outputs", {rsp_quotient, rsp_id, rsp_div0, div_dividend, div_divisor}, 0);
    check("mid_rst_req_ready", req_ready, 0);
    viol = 0;
    n = 0;
    while (!div_complete && n < 100) begin
      if (req_ready != '0 || rsp_valid || busy) viol++;
      @(negedge clk);
      n++;
    end
    if (!div_complete) note_timeout("mid_rst_divider_idle");
    check("mid_rst_no_grant_while_busy", viol, 0);
    check("mid_rst_grant_after_idle", req_ready, 4'b0010);
    acc = cyc;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(acc, lat);
    check("mid_rst_next_quotient", rsp_quotient, 32'h0000C000);
    check("mid_rst_next_id", rsp_id, 1);
    check("mid_rst_next_latency", lat, 49);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
